alu_operand_stage: RTL

Parametrised ALU operand-select stage for the MIPS datapath, sitting between register-file read and the ALU. It builds operand A (register or shift amount) and operand B (register or immediate with sign/zero/upper extension). It resolves EX and MEM forwarding and holds the result in a pipeline register with a valid/ready handshake, flush and stall.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/alu_operand_stage_if.sv | 47 ++++
 rtl/alu_operand_stage_forward.sv | 32 +++
 rtl/alu_operand_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath operand-select logic.
package mips_pkg;

    // Operand B source selection
    typedef enum logic [1:0] {
        B_RT    = 2'b00,
        B_SEXT  = 2'b01,
        B_ZEXT  = 2'b10,
        B_UPPER = 2'b11
    } b_mode_e;

    // Operand A source selection
    typedef enum logic {
        A_RS    = 1'b0,
        A_SHAMT = 1'b1
    } a_mode_e;

    // Register 0 is hard-wired and never a forwarding target
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand request / result bundle between decode, the operand stage and the ALU.
interface alu_operand_stage_if #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
);
    logic                in_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   in_rs_data;
    logic [DATA_W-1:0]   in_rt_data;
    logic [REG_AW-1:0]   in_rs_addr;
    logic [REG_AW-1:0]   in_rt_addr;
    logic [IMM_W-1:0]    in_imm;
    logic [SHAMT_W-1:0]  in_shamt;
    logic                in_a_mode;
    logic [1:0]          in_b_mode;
    logic                in_ex_wen;
    logic                in_mem_wen;
    logic [REG_AW-1:0]   in_ex_waddr;
    logic [REG_AW-1:0]   in_mem_waddr;
    logic [DATA_W-1:0]   in_ex_wdata;
    logic [DATA_W-1:0]   in_mem_wdata;
    logic                in_flush;
    logic                in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_a;
    logic [DATA_W-1:0]   out_b;
    logic [DATA_W-1:0]   out_store_data;

    modport master (
        output in_valid, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr,
               in_imm, in_shamt, in_a_mode, in_b_mode,
               in_ex_wen, in_mem_wen, in_ex_waddr, in_mem_waddr,
               in_ex_wdata, in_mem_wdata, in_flush, in_ready,
        input  out_ready, out_valid, out_a, out_b, out_store_data
    );

    modport slave (
        input  in_valid, in_rs_data, in_rt_data, in_rs_addr, in_rt_addr,
               in_imm, in_shamt, in_a_mode, in_b_mode,
               in_ex_wen, in_mem_wen, in_ex_waddr, in_mem_waddr,
               in_ex_wdata, in_mem_wdata, in_flush, in_ready,
        output out_ready, out_valid, out_a, out_b, out_store_data
    );

endinterface

// File: rtl/alu_operand_stage_forward.sv
// Combinational EX/MEM bypass for one source register; EX wins over MEM, r0 never bypassed.
module operand_forward
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] in_addr,
    input  logic [DATA_W-1:0] in_rf_data,
    input  logic              in_ex_wen,
    input  logic [REG_AW-1:0] in_ex_waddr,
    input  logic [DATA_W-1:0] in_ex_wdata,
    input  logic              in_mem_wen,
    input  logic [REG_AW-1:0] in_mem_waddr,
    input  logic [DATA_W-1:0] in_mem_wdata,
    output logic [DATA_W-1:0] out_data
);

    logic not_zero;
    assign not_zero = (in_addr != REG_AW'(REG_ZERO));

    // Priority select: youngest producer (EX) first, then MEM, then register file
    always_comb begin
        out_data = in_rf_data;
        if (not_zero && in_ex_wen && (in_ex_waddr == in_addr)) begin
            out_data = in_ex_wdata;
        end else if (not_zero && in_mem_wen && (in_mem_waddr == in_addr)) begin
            out_data = in_mem_wdata;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: forwarding, A/B source muxing and a valid/ready pipeline register.
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    alu_operand_stage_if.slave  bus
);

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] a_d, b_d, st_d;
    logic [DATA_W-1:0] a_q, b_q, st_q;
    logic              valid_d, valid_q;
    logic              load;
    b_mode_e           b_mode;
    a_mode_e           a_mode;

    operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .in_addr      (bus.in_rs_addr),
        .in_rf_data   (bus.in_rs_data),
        .in_ex_wen    (bus.in_ex_wen),
        .in_ex_waddr  (bus.in_ex_waddr),
        .in_ex_wdata  (bus.in_ex_wdata),
        .in_mem_wen   (bus.in_mem_wen),
        .in_mem_waddr (bus.in_mem_waddr),
        .in_mem_wdata (bus.in_mem_wdata),
        .out_data     (fwd_rs)
    );

    operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .in_addr      (bus.in_rt_addr),
        .in_rf_data   (bus.in_rt_data),
        .in_ex_wen    (bus.in_ex_wen),
        .in_ex_waddr  (bus.in_ex_waddr),
        .in_ex_wdata  (bus.in_ex_wdata),
        .in_mem_wen   (bus.in_mem_wen),
        .in_mem_waddr (bus.in_mem_waddr),
        .in_mem_wdata (bus.in_mem_wdata),
        .out_data     (fwd_rt)
    );

    assign a_mode        = a_mode_e'(bus.in_a_mode);
    assign b_mode        = b_mode_e'(bus.in_b_mode);
    assign bus.out_ready = !valid_q || bus.in_ready;
    assign load          = bus.in_valid && bus.out_ready && !bus.in_flush;

    // Next-state: capture on load, drain on downstream accept, flush dominates both
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        st_d    = st_q;
        valid_d = valid_q;
        if (bus.in_flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            a_d     = (a_mode == A_SHAMT) ? DATA_W'(bus.in_shamt) : fwd_rs;
            st_d    = fwd_rt;
            case (b_mode)
                B_RT:    b_d = fwd_rt;
                B_SEXT:  b_d = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
                B_ZEXT:  b_d = DATA_W'(bus.in_imm);
                B_UPPER: b_d = DATA_W'(bus.in_imm) << IMM_W;
                default: b_d = fwd_rt;
            endcase
        end else if (bus.in_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register, cleared asynchronously so a reset drops any held operation
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            st_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_q    <= st_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_a          = a_q;
    assign bus.out_b          = b_q;
    assign bus.out_store_data = st_q;

endmodule
